prefetch_fetch_unit: RTL

Parametrised successor to the single-cycle fetch stage. It decouples PC generation from instruction memory with pipelined, in-order memory requests and a prefetch queue of DEPTH entries. Each entry carries the instruction, its PC and PC+1. Decode consumes entries over a valid/ready handshake. A redirect (branch/loop jump) flushes the queue and discards in-flight responses.

---
 rtl/prefetch_fetch_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/prefetch_fetch_unit.sv
// Prefetching instruction fetch unit.
// Issues pipelined, in-order requests to instruction memory and buffers the
// responses in a DEPTH-entry queue that decode drains over valid/ready. A
// redirect flushes the queue and marks in-flight responses for discard.
// Optional build macro FETCH_STATS_EN adds saturating fetch/drop counters.
module prefetch_fetch_unit #(
    parameter int unsigned         PC_WIDTH    = 16,
    parameter int unsigned         INSTR_WIDTH = 9,
    parameter int unsigned         DEPTH       = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_en,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic [PC_WIDTH-1:0]    instr_pc_inc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]            stat_fetched,
    output logic [31:0]            stat_dropped
`endif
);

    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam logic [CW+1:0] DEPTH_C = (CW + 2)'(DEPTH);

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       outstanding_q, outstanding_d;
    logic [CW-1:0]       drop_cnt_q, drop_cnt_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;

    logic [INSTR_WIDTH-1:0] q_instr  [DEPTH];
    logic [PC_WIDTH-1:0]    q_pc     [DEPTH];
    logic [PC_WIDTH-1:0]    q_pc_inc [DEPTH];

    logic [CW+1:0] credit_used;
    logic          grant;
    logic          push;
    logic          pop;
    logic          resp_drop;

    // Handshake decode; a request is only raised when a queue slot is reserved for its response.
    always_comb begin
        credit_used = (CW + 2)'(count_q) + (CW + 2)'(outstanding_q) + (CW + 2)'(drop_cnt_q);
        imem_req    = fetch_en & ~redirect & (credit_used < DEPTH_C);
        imem_addr   = fetch_pc_q;
        grant       = imem_req & imem_gnt;
        resp_drop   = imem_rvalid & (drop_cnt_q != '0);
        push        = imem_rvalid & (drop_cnt_q == '0) & ~redirect;
        instr_valid = (count_q != '0) & ~redirect;
        pop         = instr_valid & instr_ready;
    end

    // Next-state for PCs, occupancy, credit and pointer bookkeeping.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (redirect) begin
            fetch_pc_d    = redirect_pc;
            resp_pc_d     = redirect_pc;
            count_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            // Every request still in flight is now stale; a word landing this cycle
            // retires one of them whether it came from drop_cnt or outstanding.
            drop_cnt_d    = drop_cnt_q + outstanding_q - CW'(imem_rvalid);
            outstanding_d = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
            end
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (push) begin
                wr_ptr_d  = wr_ptr_q + PW'(1);
                resp_pc_d = resp_pc_q + PC_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            outstanding_d = outstanding_q + CW'(grant) - CW'(push);
            count_d       = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Queue storage; cleared on reset so the head outputs read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i]  <= '0;
                q_pc[i]     <= '0;
                q_pc_inc[i] <= '0;
            end
        end else if (push) begin
            q_instr[wr_ptr_q]  <= imem_rdata;
            q_pc[wr_ptr_q]     <= resp_pc_q;
            q_pc_inc[wr_ptr_q] <= resp_pc_q + PC_WIDTH'(1);
        end
    end

    assign instr_out    = q_instr[rd_ptr_q];
    assign instr_pc     = q_pc[rd_ptr_q];
    assign instr_pc_inc = q_pc_inc[rd_ptr_q];

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_q;
    logic [31:0] stat_dropped_q;
    logic [31:0] drop_inc;
    logic [32:0] fetched_sum;
    logic [32:0] dropped_sum;

    // Drops are flushed entries on redirect plus every discarded response word.
    always_comb begin
        drop_inc    = redirect ? (32'(count_q) + 32'(imem_rvalid)) : 32'(resp_drop);
        fetched_sum = {1'b0, stat_fetched_q} + 33'(push);
        dropped_sum = {1'b0, stat_dropped_q} + {1'b0, drop_inc};
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched_q <= '0;
            stat_dropped_q <= '0;
        end else begin
            stat_fetched_q <= fetched_sum[32] ? '1 : fetched_sum[31:0];
            stat_dropped_q <= dropped_sum[32] ? '1 : dropped_sum[31:0];
        end
    end

    assign stat_fetched = stat_fetched_q;
    assign stat_dropped = stat_dropped_q;
`endif

endmodule
